aes_axil_slave: RTL
===================

Name: aes_axil_slave

Overview:
- AXI4-Lite slave register front-end for the AES IP; the responder to the master VIP that drives S00_AXI.
- Holds 128-bit key and plaintext registers and pulses start into the AES core.
- Captures the core's 128-bit result and exposes busy/done status to software.
- Sits between the AXI interconnect and the AES core, in the IP top level.

Parameters:
- C_S_AXI_ADDR_WIDTH, 6: byte address width; only bits [5:2] are decoded.
- C_S_AXI_DATA_WIDTH, 32: data width; 32 is the only supported value.

Ports:
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  ADDR_W/1/1  write address channel; AWPROT ignored, not a port.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR_W/1/1  read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
- aes_key  out  128  key to core; word0 = bits [31:0].
- aes_din  out  128  plaintext to core.
- aes_start  out  1  one-cycle start pulse.
- aes_dout  in  128  core result; valid when aes_done = 1.
- aes_done  in  1  one-cycle completion pulse.

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL: bit0 START, write-1 self-clearing, reads 0. bit1 IRQ_EN (optional feature only).
  - 0x04 STATUS, RO except W1C: bit0 BUSY, bit1 DONE (sticky).
  - 0x08–0x14 KEY0..3, RW.
  - 0x18–0x24 DIN0..3, RW.
  - 0x28–0x34 DOUT0..3, RO.
  - 0x38–0x3C unmapped.
- Reset: all ready/valid outputs 0, BRESP/RRESP 00, RDATA 0, all registers 0, aes_start 0.
- Write channel:
  - AW and W are accepted independently, in either order or in the same cycle.
  - AWREADY = no AW held and BVALID = 0. WREADY = no W held and BVALID = 0.
  - The cycle after both are held, the write is committed and BVALID = 1. BVALID stays high until BREADY; held AW and W are then cleared.
  - Minimum latency: AW+W handshake in cycle N gives BVALID in N+1, so back-to-back writes take 2 cycles each.
  - WSTRB gates byte lanes of RW registers.
- Write responses:
  - SLVERR (10) for unmapped addresses, DOUT, or STATUS bit0; no state change.
  - Otherwise OKAY (00). A STATUS write that only clears DONE is OKAY.
- Read channel:
  - ARREADY = !RVALID. Handshake in cycle N gives RVALID and RDATA in N+1.
  - RDATA is held stable until RREADY. Unmapped reads return RDATA 0 with RRESP SLVERR.
- Start:
  - A commit to CTRL with WDATA[0] = 1 and WSTRB[0] = 1 while BUSY = 0 pulses aes_start in the same cycle BVALID rises.
  - The same commit sets BUSY and clears DONE.
  - START while BUSY is ignored and responds OKAY.
- Completion:
  - aes_done with BUSY = 1 captures aes_dout into DOUT0..3, clears BUSY and sets DONE, all in the next cycle.
  - aes_done with BUSY = 0 is ignored.
- Simultaneous events:
  - aes_done and a W1C of DONE in the same cycle: set wins.
  - KEY/DIN writes while BUSY are accepted; the core samples them only at aes_start.
- Reset mid-transaction: all channels, BUSY and DONE are dropped; a subsequent aes_done is ignored.

Optional Feature:
- Macro: AES_AXIL_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) = DONE & CTRL.IRQ_EN, registered.
  - CTRL bit1 is RW and reset to 0.
- Undefined:
  - No irq port.
  - CTRL bit1 reads 0 and ignores writes.

Decomposition:
- Package aes_axil_pkg holds:
  - register offset localparams (ADDR_CTRL … ADDR_DOUT3);
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - CTRL/STATUS bit index constants.
- Sub-module aes_axil_wr_ctrl contains the AW/W capture and B response FSM (states IDLE, HAVE_AW, HAVE_W, RESP) and outputs a one-cycle commit strobe.
- Read path and register file stay in the top level.

Test Plan:
- Write KEY0..3 = 0x00000001..0x00000004 at 0x08–0x14, read back → identical data, RRESP 00.
- W asserted 3 cycles before AW at 0x18, WDATA 0xA5A5A5A5 → single commit, BRESP 00, DIN0 reads 0xA5A5A5A5.
- Write WSTRB = 4'b0010 to KEY0 with WDATA 0xFFFFFFFF after KEY0 = 0 → KEY0 reads 0x0000FF00.
- Write CTRL = 1 → aes_start high exactly 1 cycle, STATUS reads 0x1.
  - Then aes_done with aes_dout = 0x3925841D_02DC09FB_DC118597_196A0B32 → DOUT0 reads 0x196A0B32 and STATUS reads 0x2.
- Write 0x28 and read 0x3C → both respond SLVERR and DOUT is unchanged; second CTRL START while BUSY → no aes_start pulse.
- Hold BREADY low 5 cycles → BVALID held, AWREADY/WREADY low; with AES_AXIL_IRQ_EN, IRQ_EN = 1 and aes_done → irq = 1 until DONE is W1C'd.

Source files
------------

// File: rtl/aes_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_axil_pkg
// Brief   : Register map, response codes and helpers for the AES AXI4-Lite slave
// Revision: 1.0
// ============================================================================
package aes_axil_pkg;

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h04;
    localparam logic [5:0] ADDR_KEY0   = 6'h08;
    localparam logic [5:0] ADDR_KEY1   = 6'h0C;
    localparam logic [5:0] ADDR_KEY2   = 6'h10;
    localparam logic [5:0] ADDR_KEY3   = 6'h14;
    localparam logic [5:0] ADDR_DIN0   = 6'h18;
    localparam logic [5:0] ADDR_DIN1   = 6'h1C;
    localparam logic [5:0] ADDR_DIN2   = 6'h20;
    localparam logic [5:0] ADDR_DIN3   = 6'h24;
    localparam logic [5:0] ADDR_DOUT0  = 6'h28;
    localparam logic [5:0] ADDR_DOUT1  = 6'h2C;
    localparam logic [5:0] ADDR_DOUT2  = 6'h30;
    localparam logic [5:0] ADDR_DOUT3  = 6'h34;

    localparam logic [3:0] IDX_CTRL   = ADDR_CTRL[5:2];
    localparam logic [3:0] IDX_STATUS = ADDR_STATUS[5:2];
    localparam logic [3:0] IDX_KEY0   = ADDR_KEY0[5:2];
    localparam logic [3:0] IDX_KEY3   = ADDR_KEY3[5:2];
    localparam logic [3:0] IDX_DIN0   = ADDR_DIN0[5:2];
    localparam logic [3:0] IDX_DIN3   = ADDR_DIN3[5:2];
    localparam logic [3:0] IDX_DOUT0  = ADDR_DOUT0[5:2];
    localparam logic [3:0] IDX_DOUT3  = ADDR_DOUT3[5:2];

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_AW = 2'd1,
        HAVE_W  = 2'd2,
        RESP    = 2'd3
    } wr_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage : aes_axil_pkg
`default_nettype wire

// File: rtl/aes_axil_if.sv
`default_nettype none
// ============================================================================
// Module  : aes_axil_if
// Brief   : AXI4-Lite bus bundle with master/slave views
// Revision: 1.0
// ============================================================================
interface aes_axil_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface : aes_axil_if
`default_nettype wire

// File: rtl/aes_axil_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : aes_axil_wr_ctrl
// Brief   : AW/W capture in either order, B response hold and commit strobe
// Revision: 1.0
// ============================================================================
module aes_axil_wr_ctrl
    import aes_axil_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic                bvalid,
    input  logic                bready,
    output logic                commit,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_strb
);

    wr_state_t           r_state;
    wr_state_t           w_state_next;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                r_commit;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W/8-1:0] r_strb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        awready      = !rst && (r_state == IDLE || r_state == HAVE_W);
        wready       = !rst && (r_state == IDLE || r_state == HAVE_AW);
        bvalid       = (r_state == RESP);
        w_aw_hs      = awvalid && awready;
        w_w_hs       = wvalid && wready;
        case (r_state)
            IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_state_next = RESP;
                end else if (w_aw_hs) begin
                    w_state_next = HAVE_AW;
                end else if (w_w_hs) begin
                    w_state_next = HAVE_W;
                end
            end
            HAVE_AW: if (w_w_hs)  w_state_next = RESP;
            HAVE_W:  if (w_aw_hs) w_state_next = RESP;
            RESP:    if (bready)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Commit fires once, in the first cycle BVALID is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_data   <= '0;
            r_strb   <= '0;
            r_commit <= 1'b0;
        end else begin
            r_commit <= (r_state != RESP) && (w_state_next == RESP);
            if (w_aw_hs) begin
                r_addr <= awaddr;
            end
            if (w_w_hs) begin
                r_data <= wdata;
                r_strb <= wstrb;
            end
            if (bvalid && bready) begin
                r_addr <= '0;
                r_data <= '0;
                r_strb <= '0;
            end
        end
    end

    assign commit  = r_commit;
    assign wr_addr = r_addr;
    assign wr_data = r_data;
    assign wr_strb = r_strb;

endmodule : aes_axil_wr_ctrl
`default_nettype wire

// File: rtl/aes_axil_slave.sv
`default_nettype none
// ============================================================================
// Module  : aes_axil_slave
// Brief   : AXI4-Lite register front-end for the AES core; optional irq output
//           enabled by defining AES_AXIL_IRQ_EN.
// Revision: 1.0
// ============================================================================
module aes_axil_slave
    import aes_axil_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic         ACLK,
    input  logic         ARESET,
    aes_axil_if.slave    s_axi,
    output logic [127:0] aes_key,
    output logic [127:0] aes_din,
    output logic         aes_start,
    input  logic [127:0] aes_dout,
    input  logic         aes_done
`ifdef AES_AXIL_IRQ_EN
    ,
    output logic         irq
`endif
);

    logic                            w_commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   w_wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_wr_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] w_wr_strb;
    logic                            w_bvalid;

    logic [3:0]       w_wr_idx;
    logic [1:0]       w_wr_sel;
    logic             w_wr_err;
    logic             w_wr_ok;
    logic             w_wr_is_key;
    logic             w_wr_is_din;
    logic             w_done_clr;

    logic [3:0][31:0] r_key;
    logic [3:0][31:0] r_din;
    logic [3:0][31:0] r_dout;
    logic             r_busy;
    logic             r_done;
    logic             w_irq_en;

    logic [3:0]       w_rd_idx;
    logic [1:0]       w_rd_sel;
    logic [31:0]      w_rd_data;
    logic [1:0]       w_rd_resp;
    logic             w_arready;
    logic             r_rvalid;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;
    logic             w_unused;

    aes_axil_wr_ctrl #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH),
        .DATA_W (C_S_AXI_DATA_WIDTH)
    ) u_wr_ctrl (
        .clk     (ACLK),
        .rst     (ARESET),
        .awaddr  (s_axi.awaddr),
        .awvalid (s_axi.awvalid),
        .awready (s_axi.awready),
        .wdata   (s_axi.wdata),
        .wstrb   (s_axi.wstrb),
        .wvalid  (s_axi.wvalid),
        .wready  (s_axi.wready),
        .bvalid  (w_bvalid),
        .bready  (s_axi.bready),
        .commit  (w_commit),
        .wr_addr (w_wr_addr),
        .wr_data (w_wr_data),
        .wr_strb (w_wr_strb)
    );

    // Word index 2..13 maps to lane 0..3 by its low two bits minus two.
    assign w_wr_idx    = w_wr_addr[5:2];
    assign w_wr_sel    = w_wr_idx[1:0] - 2'd2;
    assign w_wr_is_key = (w_wr_idx >= IDX_KEY0) && (w_wr_idx <= IDX_KEY3);
    assign w_wr_is_din = (w_wr_idx >= IDX_DIN0) && (w_wr_idx <= IDX_DIN3);
    assign w_wr_err    = (w_wr_idx >= IDX_DOUT0) ||
                         ((w_wr_idx == IDX_STATUS) && w_wr_strb[0] && w_wr_data[STATUS_BUSY_BIT]);
    assign w_wr_ok     = w_commit && !w_wr_err;
    assign w_done_clr  = w_wr_ok && (w_wr_idx == IDX_STATUS) && w_wr_strb[0] &&
                         w_wr_data[STATUS_DONE_BIT];

    assign aes_start = w_wr_ok && (w_wr_idx == IDX_CTRL) && w_wr_strb[0] &&
                       w_wr_data[CTRL_START_BIT] && !r_busy;

    assign s_axi.bvalid = w_bvalid;
    assign s_axi.bresp  = (w_bvalid && w_wr_err) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_key  <= '0;
            r_din  <= '0;
            r_dout <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_wr_ok && w_wr_is_key) begin
                r_key[w_wr_sel] <= apply_strb(r_key[w_wr_sel], w_wr_data, w_wr_strb);
            end
            if (w_wr_ok && w_wr_is_din) begin
                r_din[w_wr_sel] <= apply_strb(r_din[w_wr_sel], w_wr_data, w_wr_strb);
            end
            // Completion has priority over a DONE clear landing in the same cycle.
            if (aes_start) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end else if (aes_done && r_busy) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_dout <= aes_dout;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end
        end
    end

    assign aes_key = r_key;
    assign aes_din = r_din;

`ifdef AES_AXIL_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ok && (w_wr_idx == IDX_CTRL) && w_wr_strb[0]) begin
                r_irq_en <= w_wr_data[CTRL_IRQ_EN_BIT];
            end
            r_irq <= r_done && r_irq_en;
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
`endif

    assign w_rd_idx = s_axi.araddr[5:2];
    assign w_rd_sel = w_rd_idx[1:0] - 2'd2;

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        if (w_rd_idx == IDX_CTRL) begin
            w_rd_data[CTRL_IRQ_EN_BIT] = w_irq_en;
        end else if (w_rd_idx == IDX_STATUS) begin
            w_rd_data[STATUS_BUSY_BIT] = r_busy;
            w_rd_data[STATUS_DONE_BIT] = r_done;
        end else if (w_rd_idx >= IDX_KEY0 && w_rd_idx <= IDX_KEY3) begin
            w_rd_data = r_key[w_rd_sel];
        end else if (w_rd_idx >= IDX_DIN0 && w_rd_idx <= IDX_DIN3) begin
            w_rd_data = r_din[w_rd_sel];
        end else if (w_rd_idx >= IDX_DOUT0 && w_rd_idx <= IDX_DOUT3) begin
            w_rd_data = r_dout[w_rd_sel];
        end else begin
            w_rd_resp = RESP_SLVERR;
        end
    end

    assign w_arready = !ARESET && !r_rvalid;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (s_axi.arvalid && w_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && s_axi.rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_axi.arready = w_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;

    assign w_unused = ^{s_axi.araddr[1:0], w_wr_addr[1:0]};

endmodule : aes_axil_slave
`default_nettype wire
